if_prefetch_queue: RTL and testbench

Instruction-fetch front end that sits directly upstream of the single-cycle core's decode/execute logic. It issues word reads to instruction memory over a req/ack handshake and buffers {pc, instruction} pairs in a small FIFO. It presents them to the core through a valid/ready interface. Branch/jump redirects from the core flush the queue and restart fetch at the new PC.

---
 rtl/if_prefetch_queue.sv | 127 ++++++++++++
 tb/tb_if_prefetch_queue.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | if_prefetch_queue: instruction fetch front end with {pc, inst} FIFO,      |
// | req/ack memory port and redirect flush.           Revision: 1.0          |
// +--------------------------------------------------------------------------+
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    DISCARD = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pend_addr_q, pend_addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   pc_mem_d [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   inst_mem_d [DEPTH];

  logic w_push;
  logic w_pop;

  // Request is masked while rst is high so it drops at once on an async reset.
  assign mem_req  = !rst && ((state_q == DISCARD) || (count_q < C_FULL));
  assign mem_addr = (state_q == DISCARD) ? pend_addr_q : fetch_pc_q;

  assign inst_valid = (count_q != '0);
  assign inst       = inst_mem_q[rd_ptr_q];
  assign inst_pc    = pc_mem_q[rd_ptr_q];
  assign inst_pc4   = pc_mem_q[rd_ptr_q] + 32'd4;

  assign w_push = (state_q == RUN) && mem_req && mem_ack && !redirect;
  assign w_pop  = inst_valid && inst_ready && !redirect;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pend_addr_d = pend_addr_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    pc_mem_d    = pc_mem_q;
    inst_mem_d  = inst_mem_q;

    if (redirect) begin
      count_d    = '0;
      wr_ptr_d   = rd_ptr_q;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      // An unacknowledged request must still be completed and its data dropped.
      if ((state_q == RUN) && mem_req && !mem_ack) begin
        state_d     = DISCARD;
        pend_addr_d = fetch_pc_q;
      end else if ((state_q == DISCARD) && mem_ack) begin
        state_d = RUN;
      end
    end else begin
      if ((state_q == DISCARD) && mem_ack) begin
        state_d = RUN;
      end
      if (w_push) begin
        pc_mem_d[wr_ptr_q]   = fetch_pc_q;
        inst_mem_d[wr_ptr_q] = mem_rdata;
        wr_ptr_d             = wr_ptr_q + 1'b1;
        fetch_pc_d           = fetch_pc_q + 32'd4;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      fetch_pc_q  <= RESET_PC;
      pend_addr_q <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pend_addr_q <= pend_addr_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      pc_mem_q    <= pc_mem_d;
      inst_mem_q  <= inst_mem_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_if_prefetch_queue: directed self-checking bench for if_prefetch_queue. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_if_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;

  int checks = 0;
  int errors = 0;

  // Memory model: word at byte address A holds A >> 2.
  assign mem_rdata = mem_addr >> 2;

  always #5 clk = ~clk;

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_pc4(inst_pc4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mem_ack = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    mem_ack = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
    rst = 1'b1;
    step(); step();
    checks++;
    if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: mem_req=%b inst_valid=%b, expected 0 0", mem_req, inst_valid);
    end
    checks++;
    if (inst !== 32'h0 || inst_pc !== 32'h0 || inst_pc4 !== 32'h4) begin
      errors++; $display("FAIL reset_data: inst=%h pc=%h pc4=%h, expected 0 0 4", inst, inst_pc, inst_pc4);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_first_req: mem_req=%b addr=%h, expected 1 0", mem_req, mem_addr);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    mem_ack = 1'b1; inst_ready = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(4*i) || inst !== 32'(i) || inst_pc4 !== 32'(4*i+4)) begin
        errors++;
        $display("FAIL stream[%0d]: valid=%b pc=%h inst=%h pc4=%h, expected 1 %h %h %h",
                 i, inst_valid, inst_pc, inst, inst_pc4, 32'(4*i), 32'(i), 32'(4*i+4));
      end
      step();
    end
    mem_ack = 1'b0; inst_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int reqs;
    do_reset();
    mem_ack = 1'b1; inst_ready = 1'b0;
    step(); step(); step(); step();
    checks++;
    if (mem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      errors++; $display("FAIL bp_full: mem_req=%b valid=%b pc=%h, expected 0 1 0", mem_req, inst_valid, inst_pc);
    end
    step();
    checks++;
    if (mem_req !== 1'b0 || inst_pc !== 32'h0) begin
      errors++; $display("FAIL bp_hold: mem_req=%b pc=%h, expected 0 0", mem_req, inst_pc);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10 || inst_pc !== 32'h4) begin
      errors++; $display("FAIL bp_refill: mem_req=%b addr=%h pc=%h, expected 1 10 4", mem_req, mem_addr, inst_pc);
    end
    reqs = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req === 1'b1) reqs++;
      step();
    end
    checks++;
    if (reqs != 1 || inst_pc !== 32'h4 || inst_valid !== 1'b1) begin
      errors++; $display("FAIL bp_one_req: reqs=%0d pc=%h valid=%b, expected 1 4 1", reqs, inst_pc, inst_valid);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_wait_states();
    logic [31:0] exp_addr;
    logic [31:0] exp_del;
    int          ndel;
    do_reset();
    inst_ready = 1'b1;
    exp_addr = 32'h0; exp_del = 32'h0; ndel = 0;
    for (int c = 0; c < 11; c++) begin
      mem_ack = (c % 3 == 2);
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin
        errors++; $display("FAIL ws_addr[%0d]: req=%b addr=%h, expected 1 %h", c, mem_req, mem_addr, exp_addr);
      end
      if (inst_valid === 1'b1) begin
        checks++;
        if (inst_pc !== exp_del || inst !== (exp_del >> 2)) begin
          errors++; $display("FAIL ws_order: pc=%h inst=%h, expected %h %h", inst_pc, inst, exp_del, exp_del >> 2);
        end
        exp_del = exp_del + 32'd4;
        ndel++;
      end
      step();
      if (mem_ack) exp_addr = exp_addr + 32'd4;
    end
    checks++;
    if (ndel != 3) begin
      errors++; $display("FAIL ws_count: delivered=%0d, expected 3", ndel);
    end
    mem_ack = 1'b0; inst_ready = 1'b0;
  endtask

  task automatic test_redirect_pending();
    do_reset();
    mem_ack = 1'b1;
    step(); step();
    mem_ack = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h103;
    step();
    redirect = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h8 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL rp_discard: req=%b addr=%h valid=%b, expected 1 8 0", mem_req, mem_addr, inst_valid);
    end
    step();
    checks++;
    if (mem_addr !== 32'h8) begin
      errors++; $display("FAIL rp_hold: addr=%h, expected 8", mem_addr);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL rp_restart: req=%b addr=%h valid=%b, expected 1 100 0", mem_req, mem_addr, inst_valid);
    end
    mem_ack = 1'b1; inst_ready = 1'b1;
    step();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== 32'h40) begin
      errors++; $display("FAIL rp_first: valid=%b pc=%h inst=%h, expected 1 100 40", inst_valid, inst_pc, inst);
    end
    mem_ack = 1'b0; inst_ready = 1'b0;
  endtask

  task automatic test_redirect_ack_pop();
    do_reset();
    mem_ack = 1'b1;
    step(); step(); step();
    redirect = 1'b1; redirect_pc = 32'h40; inst_ready = 1'b1;
    step();
    redirect = 1'b0; mem_ack = 1'b0; inst_ready = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h40) begin
      errors++; $display("FAIL rap_flush: valid=%b req=%b addr=%h, expected 0 1 40", inst_valid, mem_req, mem_addr);
    end
    step();
    checks++;
    if (mem_addr !== 32'h40 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL rap_no_discard: addr=%h valid=%b, expected 40 0", mem_addr, inst_valid);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst !== 32'h10) begin
      errors++; $display("FAIL rap_first: valid=%b pc=%h inst=%h, expected 1 40 10", inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_wrap_async_reset();
    do_reset();
    mem_ack = 1'b1; inst_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    checks++;
    if (mem_addr !== 32'hFFFF_FFF8 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_redir: addr=%h valid=%b, expected fffffff8 0", mem_addr, inst_valid);
    end
    step(); step(); step();
    checks++;
    if (inst_pc !== 32'hFFFF_FFF8 || inst !== 32'h3FFF_FFFE || inst_pc4 !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_0: pc=%h inst=%h pc4=%h, expected fffffff8 3ffffffe fffffffc", inst_pc, inst, inst_pc4);
    end
    inst_ready = 1'b1;
    step();
    checks++;
    if (inst_pc !== 32'hFFFF_FFFC || inst !== 32'h3FFF_FFFF || inst_pc4 !== 32'h0) begin
      errors++; $display("FAIL wrap_1: pc=%h inst=%h pc4=%h, expected fffffffc 3fffffff 0", inst_pc, inst, inst_pc4);
    end
    step();
    checks++;
    if (inst_pc !== 32'h0 || inst !== 32'h0 || inst_pc4 !== 32'h4 || inst_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_2: pc=%h inst=%h pc4=%h valid=%b, expected 0 0 4 1", inst_pc, inst, inst_pc4, inst_valid);
    end
    // Assert reset between clock edges; outputs must drop without a clock.
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL async_rst: req=%b valid=%b, expected 0 0", mem_req, inst_valid);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL async_restart: req=%b addr=%h, expected 1 0", mem_req, mem_addr);
    end
    step();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h0) begin
      errors++; $display("FAIL async_first: valid=%b pc=%h inst=%h, expected 1 0 0", inst_valid, inst_pc, inst);
    end
    mem_ack = 1'b0; inst_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_wait_states();
    test_redirect_pending();
    test_redirect_ack_pop();
    test_wrap_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
